// File: rtl/game_state_controller.sv
// Referee for the player sprite: judges hazard, fall, goal and time-out each frame, and runs the level timer, death count and restart handshake.
// Latency: one frame_clk tick from input to registered decision. No backpressure: the design is sampled unconditionally every frame.
module game_state_controller #(
    parameter int           SPRITE_W    = 20,
    parameter int           SPRITE_H    = 20,
    parameter int           HAZ_X0      = 160,
    parameter int           HAZ_X1      = 239,
    parameter int           HAZ_Y0      = 300,
    parameter int           HAZ_Y1      = 319,
    parameter int           GOAL_X0     = 400,
    parameter int           GOAL_X1     = 459,
    parameter int           GOAL_Y0     = 240,
    parameter int           GOAL_Y1     = 299,
    parameter int           FALL_Y      = 340,
    parameter int           HIT_FRAMES  = 2,
    parameter int           FPS         = 60,
    parameter int           TIME_LIMIT  = 300,
    parameter logic [7:0]   KEY_RESTART = 8'h28
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [9:0]  ManX,
    input  logic [9:0]  ManY,
    input  logic [15:0] keycode,
    output logic        Dead,
    output logic        Win,
    output logic        Restart_req,
    output logic [9:0]  seconds,
    output logic [7:0]  deaths
);

    localparam int FW  = (FPS > 1) ? $clog2(FPS) : 1;
    localparam int HCW = $clog2(HIT_FRAMES + 1);

    localparam logic [FW-1:0]  FR_LAST  = FW'(FPS - 1);
    localparam logic [HCW:0]   HF_C     = (HCW + 1)'(HIT_FRAMES);
    localparam logic [9:0]     TL_C     = 10'(TIME_LIMIT);
    localparam logic [9:0]     SEC_MAX  = 10'd999;
    localparam logic [9:0]     FALL_C   = 10'(FALL_Y);

    typedef enum logic [1:0] {ST_PLAY, ST_HIT, ST_DEAD, ST_WIN} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic [9:0]       sec_q, sec_d;
    logic [HCW-1:0]   hit_q, hit_d;
    logic [7:0]       deaths_q, deaths_d;
    logic             key_prev_q;
    logic             rr_q, rr_d;

    logic [10:0]      x_l, x_r, y_t, y_b;
    logic             haz_ovl, goal_in, fell, key_now;
    logic [HCW:0]     hit_sum;

    // Edges are 11 bits so a sprite near the 10-bit limit cannot wrap back into a rectangle
    assign x_l = {1'b0, ManX};
    assign y_t = {1'b0, ManY};
    assign x_r = x_l + 11'(SPRITE_W - 1);
    assign y_b = y_t + 11'(SPRITE_H - 1);

    assign haz_ovl = (x_l <= 11'(HAZ_X1)) && (x_r >= 11'(HAZ_X0)) &&
                     (y_t <= 11'(HAZ_Y1)) && (y_b >= 11'(HAZ_Y0));
    assign goal_in = (x_l >= 11'(GOAL_X0)) && (x_r <= 11'(GOAL_X1)) &&
                     (y_t >= 11'(GOAL_Y0)) && (y_b <= 11'(GOAL_Y1));
    assign fell    = (ManY >= FALL_C);
    assign key_now = (keycode[7:0] == KEY_RESTART) || (keycode[15:8] == KEY_RESTART);
    assign hit_sum = {1'b0, hit_q} + (HCW + 1)'(1);

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        sec_d    = sec_q;
        hit_d    = hit_q;
        deaths_d = deaths_q;
        rr_d     = 1'b0;
        case (state_q)
            ST_PLAY, ST_HIT: begin
                if (frame_q == FR_LAST) begin
                    frame_d = '0;
                    if (sec_q != SEC_MAX) sec_d = sec_q + 10'd1;
                end else begin
                    frame_d = frame_q + FW'(1);
                end
                // Position is stale while the restart pulse is high; the man block is still respawning
                if (rr_q) begin
                    hit_d   = '0;
                    state_d = ST_PLAY;
                end else if (fell || (sec_q == TL_C)) begin
                    state_d = ST_DEAD;
                end else if (haz_ovl) begin
                    hit_d   = hit_sum[HCW-1:0];
                    state_d = (hit_sum >= HF_C) ? ST_DEAD : ST_HIT;
                end else begin
                    hit_d   = '0;
                    state_d = goal_in ? ST_WIN : ST_PLAY;
                end
                if ((state_d == ST_DEAD) && (deaths_q != 8'hFF)) deaths_d = deaths_q + 8'd1;
            end
            ST_DEAD, ST_WIN: begin
                if (key_now && !key_prev_q) begin
                    rr_d    = 1'b1;
                    state_d = ST_PLAY;
                    sec_d   = '0;
                    frame_d = '0;
                    hit_d   = '0;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_PLAY;
            frame_q    <= '0;
            sec_q      <= '0;
            hit_q      <= '0;
            deaths_q   <= '0;
            key_prev_q <= 1'b0;
            rr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            sec_q      <= sec_d;
            hit_q      <= hit_d;
            deaths_q   <= deaths_d;
            key_prev_q <= key_now;
            rr_q       <= rr_d;
        end
    end

    assign Dead        = (state_q == ST_DEAD);
    assign Win         = (state_q == ST_WIN);
    assign Restart_req = rr_q;
    assign seconds     = sec_q;
    assign deaths      = deaths_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed vector bench for game_state_controller: a default-parameter instance for the main flow
// and a TIME_LIMIT=2 instance for the time-out corner.
module tb_game_state_controller;

    logic        frame_clk = 1'b0;
    logic        Reset, rst2;
    logic [9:0]  ManX, ManY, x2, y2;
    logic [15:0] keycode, key2;
    logic        Dead, Win, Restart_req, dead2, win2, rr2;
    logic [9:0]  seconds, seconds2;
    logic [7:0]  deaths, deaths2;

    int checks   = 0;
    int failures = 0;

    always #5 frame_clk = ~frame_clk;

    game_state_controller dut (
        .frame_clk(frame_clk), .Reset(Reset), .ManX(ManX), .ManY(ManY), .keycode(keycode),
        .Dead(Dead), .Win(Win), .Restart_req(Restart_req), .seconds(seconds), .deaths(deaths)
    );

    game_state_controller #(.TIME_LIMIT(2)) dut_tl (
        .frame_clk(frame_clk), .Reset(rst2), .ManX(x2), .ManY(y2), .keycode(key2),
        .Dead(dead2), .Win(win2), .Restart_req(rr2), .seconds(seconds2), .deaths(deaths2)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] key;
        logic        dead;
        logic        win;
        logic        rr;
        logic [9:0]  sec;
        logic [7:0]  dth;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [9:0] x, input logic [9:0] y, input logic [15:0] key,
                       input logic dead, input logic win, input logic rr,
                       input logic [9:0] sec, input logic [7:0] dth);
        vec_t v;
        v.x = x; v.y = y; v.key = key; v.dead = dead; v.win = win; v.rr = rr; v.sec = sec; v.dth = dth;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    function automatic logic [31:0] pack_main();
        return {11'd0, Dead, Win, Restart_req, seconds, deaths};
    endfunction

    initial begin
        int premature;
        int reached;
        int waited;

        Reset = 1'b1; rst2 = 1'b1;
        ManX = 10'd40; ManY = 10'd280; keycode = 16'h0000;
        x2 = 10'd40; y2 = 10'd280; key2 = 16'h0000;
        repeat (2) tick();
        chk("reset_state", pack_main(), 32'd0);
        Reset = 1'b0;

        // Idle at spawn: seconds ticks over on the 60th and 120th frame
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (i == 59) chk("sec_before_wrap", {22'd0, seconds}, 32'd0);
            if (i == 60) chk("sec_first_wrap", {22'd0, seconds}, 32'd1);
        end
        chk("idle_120", pack_main(), {11'd0, 1'b0, 1'b0, 1'b0, 10'd2, 8'd0});

        //   x     y     key       dead  win   rr    sec    deaths
        add(170, 290, 16'h0000, 1'b0, 1'b0, 1'b0, 10'd2, 8'd0);  // single hazard frame
        add( 40, 280, 16'h0000, 1'b0, 1'b0, 1'b0, 10'd2, 8'd0);  // back to PLAY, hit count cleared
        add(170, 290, 16'h0000, 1'b0, 1'b0, 1'b0, 10'd2, 8'd0);
        add(170, 290, 16'h0000, 1'b1, 1'b0, 1'b0, 10'd2, 8'd1);  // second consecutive -> dead
        add(170, 290, 16'h0000, 1'b1, 1'b0, 1'b0, 10'd2, 8'd1);  // counted once
        add( 40, 280, 16'h0000, 1'b1, 1'b0, 1'b0, 10'd2, 8'd1);  // timer frozen
        add( 40, 280, 16'h0028, 1'b0, 1'b0, 1'b1, 10'd0, 8'd1);  // restart from dead
        add( 40, 280, 16'h0028, 1'b0, 1'b0, 1'b0, 10'd0, 8'd1);
        add(420, 260, 16'h0028, 1'b0, 1'b1, 1'b0, 10'd0, 8'd1);  // goal -> win
        add(420, 260, 16'h0000, 1'b0, 1'b1, 1'b0, 10'd0, 8'd1);
        add(420, 260, 16'h0028, 1'b0, 1'b0, 1'b1, 10'd0, 8'd1);  // Enter edge: restart
        add(420, 260, 16'h0028, 1'b0, 1'b0, 1'b0, 10'd0, 8'd1);  // stale goal position ignored
        add( 40, 280, 16'h0028, 1'b0, 1'b0, 1'b0, 10'd0, 8'd1);  // held key: no retrigger
        add( 40, 280, 16'h0028, 1'b0, 1'b0, 1'b0, 10'd0, 8'd1);
        add( 40, 280, 16'h0028, 1'b0, 1'b0, 1'b0, 10'd0, 8'd1);
        add( 40, 345, 16'h0000, 1'b1, 1'b0, 1'b0, 10'd0, 8'd2);  // fell off
        add( 40, 345, 16'h2800, 1'b0, 1'b0, 1'b1, 10'd0, 8'd2);  // key in upper slot
        add( 40, 345, 16'h2800, 1'b0, 1'b0, 1'b0, 10'd0, 8'd2);  // stale fall position ignored
        add( 40, 280, 16'h0000, 1'b0, 1'b0, 1'b0, 10'd0, 8'd2);
        add( 40, 280, 16'h0028, 1'b0, 1'b0, 1'b0, 10'd0, 8'd2);  // key ignored while playing
        add( 40, 280, 16'h0000, 1'b0, 1'b0, 1'b0, 10'd0, 8'd2);

        for (int i = 0; i < vq.size(); i++) begin
            ManX = vq[i].x; ManY = vq[i].y; keycode = vq[i].key;
            tick();
            chk($sformatf("row%0d", i), pack_main(),
                {11'd0, vq[i].dead, vq[i].win, vq[i].rr, vq[i].sec, vq[i].dth});
        end

        // Fall again, then async reset in the middle of a frame
        ManY = 10'd345;
        tick();
        chk("fall_dead", {24'd0, 4'd0, Dead, Win, 2'd0}, {24'd0, 4'd0, 1'b1, 1'b0, 2'd0});
        chk("deaths_3", {24'd0, deaths}, 32'd3);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset", pack_main(), 32'd0);
        tick();
        Reset = 1'b0;

        // Time-limit instance: idle until seconds reaches 2, then move into the goal
        rst2 = 1'b0;
        premature = 0;
        reached = 0;
        waited = 0;
        while (!reached && waited < 400) begin
            tick();
            waited++;
            if (seconds2 == 10'd2) reached = 1;
            else if (dead2) premature++;
        end
        chk("tl_reached", reached, 1);
        chk("tl_no_early_death", premature, 0);
        x2 = 10'd420; y2 = 10'd260;
        tick();
        chk("tl_death_beats_win", {30'd0, dead2, win2}, {30'd0, 1'b1, 1'b0});
        chk("tl_deaths", {24'd0, deaths2}, 32'd1);
        repeat (70) tick();
        chk("tl_frozen", {21'd0, dead2, seconds2}, {21'd0, 1'b1, 10'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
